// File: rtl/main_write_drain.sv
// Drains the cache-to-main write FIFO: pops one (data, addr) entry, issues it as a
// single-word write held until mem_ack, counts completions and flags errors.
module main_write_drain #(
    parameter int FIFO_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [FIFO_WIDTH-1:0] fifo_data_i,
    input  logic [FIFO_WIDTH-1:0] fifo_addr_i,
    output logic                  fifo_pop_o,
    output logic                  mem_we_o,
    output logic [FIFO_WIDTH-1:0] mem_addr_o,
    output logic [FIFO_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    output logic                  busy_o,
    output logic                  err_timeout_o,
    output logic                  err_misalign_o,
    output logic [FIFO_WIDTH-1:0] err_addr_o,
    input  logic                  err_clr_i,
    output logic [CNT_WIDTH-1:0]  wr_count_o
);

    // state   | meaning
    // S_IDLE  | waiting for a FIFO entry; pops as soon as one is available
    // S_LOAD  | popped entry is on fifo_data/fifo_addr; check alignment, latch it
    // S_WRITE | mem_we held with stable addr/data until ack or timeout
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [FIFO_WIDTH-1:0] addr_q, addr_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  eto_q, eto_d;
    logic                  emis_q, emis_d;
    logic [FIFO_WIDTH-1:0] eaddr_q, eaddr_d;
    logic                  pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            eto_q   <= 1'b0;
            emis_q  <= 1'b0;
            eaddr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            eto_q   <= eto_d;
            emis_q  <= emis_d;
            eaddr_q <= eaddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        // Clear first so a same-cycle new error below overrides it.
        eto_d   = err_clr_i ? 1'b0 : eto_q;
        emis_d  = err_clr_i ? 1'b0 : emis_q;
        eaddr_d = eaddr_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_i) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (fifo_addr_i[1:0] != 2'b00) begin
                    emis_d  = 1'b1;
                    eaddr_d = fifo_addr_i;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = fifo_addr_i;
                    data_d  = fifo_data_i;
                    tmo_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ack_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (!fifo_empty_i) begin
                        pop     = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    eto_d   = 1'b1;
                    eaddr_d = addr_q;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pop is combinational; suppress it while reset is held so no entry is consumed.
    assign fifo_pop_o     = pop & ~rst_i;
    assign mem_we_o       = (state_q == S_WRITE);
    assign busy_o         = (state_q != S_IDLE);
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = data_q;
    assign err_timeout_o  = eto_q;
    assign err_misalign_o = emis_q;
    assign err_addr_o     = eaddr_q;
    assign wr_count_o     = cnt_q;

endmodule
